// File: rtl/orv64_pipe_hzd_ctrl_if.sv
// Hazard controller bundle: stage valids and hazard events in,
// per-stage stall/kill plus redirect and flush controls out.
interface orv64_pipe_hzd_ctrl_if;
  logic       if_valid;
  logic       id_valid;
  logic       ex_valid;
  logic       ma_valid;
  logic       id_load_use;
  logic       ma_dc_wait;
  logic       ex_redirect;
  logic       ma_excp;
  logic       ma_fence;
  logic       cache_flush_done;
  logic       dbg_halt_req;
  logic       dbg_resume_req;
  logic       if_stall;
  logic       id_stall;
  logic       ex_stall;
  logic       ma_stall;
  logic       if_kill;
  logic       id_kill;
  logic       ex_kill;
  logic       ma_kill;
  logic       pc_redirect_valid;
  logic [1:0] pc_redirect_sel;
  logic       cache_flush_req;
  logic       halted;
  logic       drain_timeout_err;

  modport master (
    input  if_valid, id_valid, ex_valid, ma_valid,
    input  id_load_use, ma_dc_wait, ex_redirect,
    input  ma_excp, ma_fence, cache_flush_done,
    input  dbg_halt_req, dbg_resume_req,
    output if_stall, id_stall, ex_stall, ma_stall,
    output if_kill, id_kill, ex_kill, ma_kill,
    output pc_redirect_valid, pc_redirect_sel,
    output cache_flush_req, halted, drain_timeout_err
  );

  modport slave (
    output if_valid, id_valid, ex_valid, ma_valid,
    output id_load_use, ma_dc_wait, ex_redirect,
    output ma_excp, ma_fence, cache_flush_done,
    output dbg_halt_req, dbg_resume_req,
    input  if_stall, id_stall, ex_stall, ma_stall,
    input  if_kill, id_kill, ex_kill, ma_kill,
    input  pc_redirect_valid, pc_redirect_sel,
    input  cache_flush_req, halted, drain_timeout_err
  );
endinterface

// File: rtl/orv64_pipe_hzd_ctrl.sv
// orv64 central hazard/flush controller: arbitrates pipeline hazards
// and sequences fence.i drain and debug halt.
module orv64_pipe_hzd_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  orv64_pipe_hzd_ctrl_if.master hz
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic excp, fence, redir, dcw, lu, done, tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    excp  = hz.ma_valid & hz.ma_excp;
    fence = hz.ma_valid & hz.ma_fence;
    dcw   = hz.ma_valid & hz.ma_dc_wait;
    redir = hz.ex_valid & hz.ex_redirect;
    lu    = hz.id_valid & hz.ex_valid & hz.id_load_use;
    done  = hz.cache_flush_done;
    tmo   = (cnt_q == CNT_LAST);

    st_d  = st_q;
    cnt_d = cnt_q;
    err_d = err_q;

    hz.if_stall          = 1'b0;
    hz.id_stall          = 1'b0;
    hz.ex_stall          = 1'b0;
    hz.ma_stall          = 1'b0;
    hz.if_kill           = 1'b0;
    hz.id_kill           = 1'b0;
    hz.ex_kill           = 1'b0;
    hz.ma_kill           = 1'b0;
    hz.pc_redirect_valid = 1'b0;
    hz.pc_redirect_sel   = 2'd0;
    hz.cache_flush_req   = 1'b0;
    hz.halted            = 1'b0;
    hz.drain_timeout_err = err_q;

    unique case (st_q)
      S_DRAIN: begin
        hz.cache_flush_req = 1'b1;
        hz.if_stall        = 1'b1;
        hz.id_stall        = 1'b1;
        hz.ex_stall        = 1'b1;
        hz.ma_stall        = 1'b1;
        hz.if_kill         = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // done wins over a coincident timeout, so no error then
        if (done || tmo) begin
          hz.pc_redirect_valid = 1'b1;
          hz.pc_redirect_sel   = 2'd2;
          st_d                 = S_RUN;
          if (!done) err_d = 1'b1;
        end
      end
      S_HALT: begin
        hz.halted   = 1'b1;
        hz.if_stall = 1'b1;
        hz.if_kill  = 1'b1;
        if (hz.dbg_resume_req) begin
          hz.pc_redirect_valid = 1'b1;
          hz.pc_redirect_sel   = 2'd3;
          st_d                 = S_RUN;
        end
      end
      default: begin
        if (excp) begin
          hz.if_kill           = 1'b1;
          hz.id_kill           = 1'b1;
          hz.ex_kill           = 1'b1;
          hz.ma_kill           = 1'b1;
          hz.pc_redirect_valid = 1'b1;
          hz.pc_redirect_sel   = 2'd1;
        end else if (fence) begin
          hz.if_kill = 1'b1;
          hz.id_kill = 1'b1;
          hz.ex_kill = 1'b1;
          st_d       = S_DRAIN;
          cnt_d      = '0;
        end else if (hz.dbg_halt_req) begin
          hz.if_kill = 1'b1;
          hz.id_kill = 1'b1;
          hz.ex_kill = 1'b1;
          st_d       = S_HALT;
        end else if (redir) begin
          hz.if_kill           = 1'b1;
          hz.id_kill           = 1'b1;
          hz.pc_redirect_valid = 1'b1;
        end else if (dcw) begin
          hz.if_stall = 1'b1;
          hz.id_stall = 1'b1;
          hz.ex_stall = 1'b1;
          hz.ma_stall = 1'b1;
        end else if (lu) begin
          hz.if_stall = 1'b1;
          hz.id_stall = 1'b1;
          hz.id_kill  = 1'b1;
        end
      end
    endcase

    // reset flushes every stage regardless of the held state
    if (rst) begin
      hz.if_stall          = 1'b0;
      hz.id_stall          = 1'b0;
      hz.ex_stall          = 1'b0;
      hz.ma_stall          = 1'b0;
      hz.if_kill           = 1'b1;
      hz.id_kill           = 1'b1;
      hz.ex_kill           = 1'b1;
      hz.ma_kill           = 1'b1;
      hz.pc_redirect_valid = 1'b0;
      hz.pc_redirect_sel   = 2'd0;
      hz.cache_flush_req   = 1'b0;
      hz.halted            = 1'b0;
      hz.drain_timeout_err = 1'b0;
      st_d                 = S_RUN;
      cnt_d                = '0;
      err_d                = 1'b0;
    end
  end

endmodule

// File: tb/tb_orv64_pipe_hzd_ctrl.sv
// Directed bench for orv64_pipe_hzd_ctrl: DUT a uses the default
// drain window, DUT b a 4-cycle window; both see the same stimulus.
module tb_orv64_pipe_hzd_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic if_v, id_v, ex_v, ma_v;
  logic lu, dcw, redir, excp, fence, done, hreq, rreq;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  orv64_pipe_hzd_ctrl_if ua ();
  orv64_pipe_hzd_ctrl_if ub ();

  assign ua.if_valid         = if_v;
  assign ua.id_valid         = id_v;
  assign ua.ex_valid         = ex_v;
  assign ua.ma_valid         = ma_v;
  assign ua.id_load_use      = lu;
  assign ua.ma_dc_wait       = dcw;
  assign ua.ex_redirect      = redir;
  assign ua.ma_excp          = excp;
  assign ua.ma_fence         = fence;
  assign ua.cache_flush_done = done;
  assign ua.dbg_halt_req     = hreq;
  assign ua.dbg_resume_req   = rreq;

  assign ub.if_valid         = if_v;
  assign ub.id_valid         = id_v;
  assign ub.ex_valid         = ex_v;
  assign ub.ma_valid         = ma_v;
  assign ub.id_load_use      = lu;
  assign ub.ma_dc_wait       = dcw;
  assign ub.ex_redirect      = redir;
  assign ub.ma_excp          = excp;
  assign ub.ma_fence         = fence;
  assign ub.cache_flush_done = done;
  assign ub.dbg_halt_req     = hreq;
  assign ub.dbg_resume_req   = rreq;

  orv64_pipe_hzd_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .hz  (ua.master)
  );

  orv64_pipe_hzd_ctrl #(.DRAIN_TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (ub.master)
  );

  wire [3:0] a_st = {ua.if_stall, ua.id_stall, ua.ex_stall, ua.ma_stall};
  wire [3:0] a_kl = {ua.if_kill, ua.id_kill, ua.ex_kill, ua.ma_kill};
  wire [2:0] a_rd = {ua.pc_redirect_valid, ua.pc_redirect_sel};
  wire [3:0] b_st = {ub.if_stall, ub.id_stall, ub.ex_stall, ub.ma_stall};
  wire [3:0] b_kl = {ub.if_kill, ub.id_kill, ub.ex_kill, ub.ma_kill};
  wire [2:0] b_rd = {ub.pc_redirect_valid, ub.pc_redirect_sel};

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lu = 0; dcw = 0; redir = 0; excp = 0;
    fence = 0; done = 0; hreq = 0; rreq = 0;
  endtask

  initial begin
    rst = 1'b1;
    if_v = 1; id_v = 1; ex_v = 1; ma_v = 1;
    clr();
    tick(); #1;
    chk("rst_kill", 8'(a_kl), 8'hF);
    chk("rst_stall", 8'(a_st), 8'h0);
    chk("rst_redir", 8'(a_rd), 8'h0);
    chk("rst_misc", 8'({ua.cache_flush_req, ua.halted,
                        ua.drain_timeout_err}), 8'h0);
    tick();
    rst = 1'b0; #1;
    chk("idle_kill", 8'(a_kl), 8'h0);
    chk("idle_stall", 8'(a_st), 8'h0);

    // load-use
    tick(); lu = 1; #1;
    chk("lu_stall", 8'(a_st), 8'hC);
    chk("lu_kill", 8'(a_kl), 8'h4);
    chk("lu_redir", 8'(a_rd), 8'h0);
    ex_v = 0; #1;
    chk("lu_unq_stall", 8'(a_st), 8'h0);
    ex_v = 1;

    tick(); clr(); dcw = 1; #1;
    chk("dcw_stall", 8'(a_st), 8'hF);
    chk("dcw_kill", 8'(a_kl), 8'h0);

    tick(); clr(); redir = 1; #1;
    chk("br_kill", 8'(a_kl), 8'hC);
    chk("br_redir", 8'(a_rd), 8'h4);

    tick(); excp = 1; #1;
    chk("excp_kill", 8'(a_kl), 8'hF);
    chk("excp_redir", 8'(a_rd), 8'h5);
    ma_v = 0; #1;
    chk("excp_unq_redir", 8'(a_rd), 8'h4);
    ma_v = 1;

    // fence: cycle 0
    tick(); clr(); fence = 1; #1;
    chk("fen0_kill", 8'(a_kl), 8'hE);
    chk("fen0_flush", 8'(ua.cache_flush_req), 8'h0);
    tick(); clr(); #1;
    chk("fen1_flush", 8'(ua.cache_flush_req), 8'h1);
    chk("fen1_stall", 8'(a_st), 8'hF);
    chk("fen1_kill", 8'(a_kl), 8'h8);
    tick(); tick(); #1;
    chk("fen3_b_redir", 8'(b_rd), 8'h0);
    tick(); #1;
    chk("fen4_b_redir", 8'(b_rd), 8'h6);
    chk("fen4_a_redir", 8'(a_rd), 8'h0);
    chk("fen4_b_err", 8'(ub.drain_timeout_err), 8'h0);
    tick(); done = 1; #1;
    chk("fen5_a_redir", 8'(a_rd), 8'h6);
    chk("fen5_b_ignore", 8'(b_rd), 8'h0);
    chk("fen5_b_err", 8'(ub.drain_timeout_err), 8'h1);
    tick(); clr(); #1;
    chk("fen6_a_flush", 8'(ua.cache_flush_req), 8'h0);
    chk("fen6_a_err", 8'(ua.drain_timeout_err), 8'h0);
    chk("fen6_b_err", 8'(ub.drain_timeout_err), 8'h1);

    // debug halt
    tick(); hreq = 1; #1;
    chk("h0_kill", 8'(a_kl), 8'hE);
    chk("h0_halted", 8'(ua.halted), 8'h0);
    tick(); clr(); #1;
    chk("h1_halted", 8'(ua.halted), 8'h1);
    chk("h1_stall", 8'(a_st), 8'h8);
    chk("h1_kill", 8'(a_kl), 8'h8);
    tick(); excp = 1; redir = 1; lu = 1; #1;
    chk("h2_excp_kill", 8'(a_kl), 8'h8);
    chk("h2_excp_redir", 8'(a_rd), 8'h0);
    for (int i = 3; i < 10; i++) tick();
    clr(); rreq = 1; hreq = 1; #1;
    chk("h10_redir", 8'(a_rd), 8'h7);
    chk("h10_halted", 8'(ua.halted), 8'h1);
    tick(); clr(); #1;
    chk("h11_halted", 8'(ua.halted), 8'h0);
    chk("h11_kill", 8'(a_kl), 8'h0);

    // reset mid-drain, then a fresh full window on DUT b
    tick(); fence = 1; #1;
    tick(); clr(); #1;
    chk("rd1_flush", 8'(ub.cache_flush_req), 8'h1);
    tick(); rst = 1; #1;
    chk("rd2_kill", 8'(b_kl), 8'hF);
    chk("rd2_misc", 8'({ub.cache_flush_req, ub.halted,
                        ub.drain_timeout_err}), 8'h0);
    tick(); rst = 0; #1;
    chk("rd3_flush", 8'(ub.cache_flush_req), 8'h0);
    chk("rd3_stall", 8'(b_st), 8'h0);
    chk("rd3_err", 8'(ub.drain_timeout_err), 8'h0);
    tick(); fence = 1; #1;
    tick(); clr(); #1;
    tick(); tick(); #1;
    chk("rf3_flush", 8'(ub.cache_flush_req), 8'h1);
    chk("rf3_redir", 8'(b_rd), 8'h0);
    tick(); #1;
    chk("rf4_redir", 8'(b_rd), 8'h6);
    tick(); #1;
    chk("rf5_err", 8'(ub.drain_timeout_err), 8'h1);
    chk("rf5_flush", 8'(ub.cache_flush_req), 8'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
